sig_debounce: RTL and testbench
===============================

Name: sig_debounce

Overview:
- Input conditioning stage directly upstream of chng_det.
- Synchronises the asynchronous raw_sig into the clk domain through a flop chain, then rejects transitions shorter than DB_CYCLES samples.
- Drives the cleaned level on sig_out, which connects to chng_det.sig.
- Counts rejected glitches for debug visibility.

Parameters:
- SYNC_STAGES, 2: synchroniser flop depth; legal range 2..4.
- DB_CYCLES, 4: consecutive stable samples required to accept a new level; legal range 2..255.
- GLITCH_W, 8: width of the glitch counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- raw_sig  in  1  asynchronous raw input.
- db_en  in  1  1 = debounce active; 0 = bypass (synchronised only).
- glitch_clr  in  1  synchronous clear of glitch_cnt.
- sig_out  out  1  debounced level; feeds chng_det.sig.
- sig_valid  out  1  1 once sig_out holds an established level after reset.
- glitch_cnt  out  GLITCH_W  saturating count of rejected transitions.

Behaviour:
- Reset (rst=1 at an edge): all sync flops=0, sig_out=0, sig_valid=0, glitch_cnt=0, state=INIT, cand=0, cnt=0. Reset has priority over every other input, including mid-CHECK.
- sync_q = last flop of the chain. It reflects raw_sig sampled at edge E0 after edge E0+SYNC_STAGES-1. The FSM below evaluates sync_q as registered before each edge.
- INIT, evaluated each edge:
  - sync_q!=cand: cand<=sync_q, cnt<=1.
  - Else if cnt==DB_CYCLES-1: sig_out<=cand, sig_valid<=1, cnt<=0, go STABLE.
  - Else: cnt<=cnt+1.
- STABLE:
  - sync_q!=sig_out: cnt<=1, go CHECK.
  - Else: hold.
- CHECK:
  - sync_q==sig_out: glitch, go STABLE, cnt<=0, glitch_cnt+1 (saturates at all-ones).
  - Else if cnt==DB_CYCLES-1: sig_out<=~sig_out, cnt<=0, go STABLE.
  - Else: cnt<=cnt+1.
- Latency: a clean raw change first sampled at edge E0 appears on sig_out after edge E0+SYNC_STAGES+DB_CYCLES-1. A raw pulse shorter than DB_CYCLES cycles never reaches sig_out.
- Bypass (db_en=0):
  - sig_out<=sync_q every edge, sig_valid<=1, state forced STABLE, cnt<=0.
  - glitch_cnt only holds or clears.
  - Dropping db_en mid-CHECK aborts without counting a glitch.
  - Raising db_en resumes in STABLE using the current sig_out.
- glitch_clr=1: glitch_cnt<=0. Clear wins over a simultaneous glitch increment.
- sig_out changes at most once per DB_CYCLES edges while db_en=1.
- sig_valid never deasserts except on rst.
- cnt width = clog2(DB_CYCLES); no wrap is possible because of the ==DB_CYCLES-1 compare.

Decomposition:
- debounce_pkg: state enum typedef (INIT, STABLE, CHECK) and function clog2.
- Sub-module sync_chain (parameter SYNC_STAGES; ports clk, rst, d, q): reset flop chain, reused by other async inputs in the design.

Test Plan (SYNC_STAGES=2, DB_CYCLES=4, GLITCH_W=8 unless stated):
- Release rst with raw_sig=1 held -> sig_valid=1 and sig_out=1 after the 6th edge; with raw_sig=0 held -> sig_valid=1, sig_out=0 after the 4th edge.
- STABLE at 0; raw_sig 0->1 first sampled at E0 and held -> sig_out stays 0 through E0+4 and reads 1 after E0+5; glitch_cnt stays 0.
- raw_sig high pulses of 1, 2 and 3 cycles -> sig_out stays 0, glitch_cnt=3. A following 4-cycle pulse -> sig_out=1 after E0+5, glitch_cnt stays 3.
- GLITCH_W=2, five 2-cycle pulses -> glitch_cnt saturates at 3. Then glitch_clr=1 coinciding with a glitch-return edge -> glitch_cnt=0.
- db_en=0, 1-cycle raw pulse at E0 -> sig_out=1 for exactly one cycle, after edge E0+2; glitch_cnt unchanged.
- rst=1 during CHECK (cnt=2) -> next cycle sig_out=0, sig_valid=0, glitch_cnt=0. The INIT sequence repeats as in scenario 1.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input-conditioning (debounce) blocks.
package debounce_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        STABLE = 2'd1,
        CHECK  = 2'd2
    } db_state_t;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Reset flop chain bringing an asynchronous input into the clk domain.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// Synchronises raw_sig and accepts a new level only after DB_CYCLES stable samples;
// rejected transitions are counted in a saturating glitch counter.
module sig_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4,
    parameter int unsigned GLITCH_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw_sig,
    input  logic                db_en,
    input  logic                glitch_clr,
    output logic                sig_out,
    output logic                sig_valid,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned      CNT_W    = clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic                sync_q;
    db_state_t           state_q, state_d;
    logic                cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_q, out_d;
    logic                valid_q, valid_d;
    logic [GLITCH_W-1:0] gcnt_q, gcnt_d;
    logic                glitch;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_sig),
        .q   (sync_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cand_q  <= 1'b0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            gcnt_q  <= gcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        glitch  = 1'b0;

        // Bypass overrides the FSM; leaving it resumes in STABLE on the current level.
        if (!db_en) begin
            state_d = STABLE;
            out_d   = sync_q;
            valid_d = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (sync_q != cand_q) begin
                        cand_d = sync_q;
                        cnt_d  = CNT_W'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        out_d   = cand_q;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (sync_q != out_q) begin
                        cnt_d   = CNT_W'(1);
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (sync_q == out_q) begin
                        glitch  = 1'b1;
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else if (cnt_q == CNT_LAST) begin
                        out_d   = ~out_q;
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            endcase
        end

        if (glitch_clr)                  gcnt_d = '0;
        else if (glitch && gcnt_q != '1) gcnt_d = gcnt_q + GLITCH_W'(1);
        else                             gcnt_d = gcnt_q;
    end

    assign sig_out    = out_q;
    assign sig_valid  = valid_q;
    assign glitch_cnt = gcnt_q;

endmodule

// File: tb/tb_sig_debounce.sv
// Bench for sig_debounce: directed scenarios plus random stimulus against a run-length model.
module tb_sig_debounce;

    localparam int unsigned SS = 2;
    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       raw_sig = 1'b0;
    logic       db_en = 1'b1;
    logic       glitch_clr = 1'b0;
    logic       sig_out, sig_valid, sig_out2, sig_valid2;
    logic [7:0] glitch_cnt;
    logic [1:0] glitch_cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    sig_debounce #(.SYNC_STAGES(SS), .DB_CYCLES(DB), .GLITCH_W(8)) u_dut (
        .clk(clk), .rst(rst), .raw_sig(raw_sig), .db_en(db_en), .glitch_clr(glitch_clr),
        .sig_out(sig_out), .sig_valid(sig_valid), .glitch_cnt(glitch_cnt)
    );

    sig_debounce #(.SYNC_STAGES(SS), .DB_CYCLES(DB), .GLITCH_W(2)) u_sat (
        .clk(clk), .rst(rst), .raw_sig(raw_sig), .db_en(db_en), .glitch_clr(glitch_clr),
        .sig_out(sig_out2), .sig_valid(sig_valid2), .glitch_cnt(glitch_cnt2)
    );

    always #5 clk = ~clk;

    // Reference model: raw history delayed by the synchroniser, and the run of samples
    // pending acceptance since the last accepted level / rejected glitch.
    bit m_known = 0;
    bit m_init, m_out, m_valid;
    int m_g;
    bit rawq[$];
    bit hist[$];

    task automatic model_edge();
        bit s, all_same, glitch;
        glitch = 0;
        if (rst) begin
            m_known = 1;
            m_init  = 1;
            m_out   = 0;
            m_valid = 0;
            m_g     = 0;
            hist.delete();
            rawq.delete();
            for (int i = 0; i < SS; i++) rawq.push_back(1'b0);
        end else if (m_known) begin
            s = rawq.pop_front();
            rawq.push_back(raw_sig);
            if (!db_en) begin
                m_out = s; m_valid = 1; m_init = 0;
                hist.delete();
            end else if (m_init) begin
                hist.push_back(s);
                if (hist.size() > DB) void'(hist.pop_front());
                all_same = (hist.size() == DB);
                foreach (hist[i]) if (hist[i] != s) all_same = 0;
                if (all_same) begin
                    m_out = s; m_valid = 1; m_init = 0;
                    hist.delete();
                end
            end else if (s == m_out) begin
                if (hist.size() > 0) glitch = 1;
                hist.delete();
            end else begin
                hist.push_back(s);
                if (hist.size() == DB) begin
                    m_out = ~m_out;
                    hist.delete();
                end
            end
            if (glitch_clr)  m_g = 0;
            else if (glitch) m_g = m_g + 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (m_known) begin
            check("sig_out", 32'(sig_out), 32'(m_out));
            check("sig_valid", 32'(sig_valid), 32'(m_valid));
            check("glitch_cnt8", 32'(glitch_cnt), (m_g > 255) ? 32'd255 : 32'(m_g));
            check("sig_out_w2", 32'(sig_out2), 32'(m_out));
            check("glitch_cnt2", 32'(glitch_cnt2), (m_g > 3) ? 32'd3 : 32'(m_g));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int len, input int gap);
        raw_sig = 1'b1;
        ticks(len);
        raw_sig = 1'b0;
        ticks(gap);
    endtask

    initial begin
        int unsigned len;
        bit lvl;

        // Reset release with raw high: accepted after the 6th edge.
        rst = 1; raw_sig = 1; ticks(2);
        check("rst_out", 32'(sig_out), 0);
        check("rst_valid", 32'(sig_valid), 0);
        rst = 0; ticks(5);
        check("init1_valid_e5", 32'(sig_valid), 0);
        tick();
        check("init1_valid_e6", 32'(sig_valid), 1);
        check("init1_out_e6", 32'(sig_out), 1);

        // Reset release with raw low: accepted after the 4th edge.
        rst = 1; raw_sig = 0; ticks(2);
        rst = 0; ticks(3);
        check("init0_valid_e3", 32'(sig_valid), 0);
        tick();
        check("init0_valid_e4", 32'(sig_valid), 1);
        check("init0_out_e4", 32'(sig_out), 0);

        // Clean rising edge: latency SYNC_STAGES+DB_CYCLES-1.
        ticks(2);
        raw_sig = 1; ticks(5);
        check("rise_out_e4", 32'(sig_out), 0);
        tick();
        check("rise_out_e5", 32'(sig_out), 1);
        raw_sig = 0; ticks(8);
        check("fall_out", 32'(sig_out), 0);
        check("clean_glitch", 32'(glitch_cnt), 0);

        // Short pulses are rejected and counted; a DB_CYCLES pulse passes.
        pulse(1, 8); pulse(2, 8); pulse(3, 8);
        check("short_out", 32'(sig_out), 0);
        check("short_glitch", 32'(glitch_cnt), 3);
        raw_sig = 1; ticks(4);
        raw_sig = 0; tick();
        check("long_out_e4", 32'(sig_out), 0);
        tick();
        check("long_out_e5", 32'(sig_out), 1);
        ticks(10);
        check("long_glitch", 32'(glitch_cnt), 3);

        // Saturation on the 2-bit instance, then clear racing a glitch increment.
        for (int i = 0; i < 5; i++) pulse(2, 6);
        check("sat_w2", 32'(glitch_cnt2), 3);
        check("sat_w8", 32'(glitch_cnt), 8);
        raw_sig = 1; ticks(2);
        raw_sig = 0; ticks(2);
        glitch_clr = 1; tick();
        glitch_clr = 0;
        check("clr_w2", 32'(glitch_cnt2), 0);
        check("clr_w8", 32'(glitch_cnt), 0);
        ticks(4);

        // Bypass: a one-cycle pulse shows up for exactly one cycle after E0+2.
        db_en = 0; ticks(2);
        raw_sig = 1; tick();
        raw_sig = 0; tick();
        check("byp_out_e1", 32'(sig_out), 0);
        tick();
        check("byp_out_e2", 32'(sig_out), 1);
        tick();
        check("byp_out_e3", 32'(sig_out), 0);
        check("byp_glitch", 32'(glitch_cnt), 0);
        db_en = 1; ticks(3);

        // Reset while in CHECK with cnt=2.
        pulse(1, 6);
        check("pre_rst_glitch", 32'(glitch_cnt), 1);
        raw_sig = 1; ticks(4);
        rst = 1; tick();
        check("midrst_out", 32'(sig_out), 0);
        check("midrst_valid", 32'(sig_valid), 0);
        check("midrst_glitch", 32'(glitch_cnt), 0);
        rst = 0; ticks(5);
        check("reinit_valid_e5", 32'(sig_valid), 0);
        tick();
        check("reinit_valid_e6", 32'(sig_valid), 1);
        check("reinit_out_e6", 32'(sig_out), 1);

        // Random runs of raw levels with occasional bypass, clears and resets.
        lvl = 1;
        for (int seg = 0; seg < 500; seg++) begin
            lvl = ~lvl;
            raw_sig = lvl;
            db_en = ($urandom_range(0, 99) < 8) ? 1'b0 : 1'b1;
            rst = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
            len = $urandom_range(1, 7);
            for (int c = 0; c < int'(len); c++) begin
                glitch_clr = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
                tick();
                rst = 1'b0;
            end
        end
        glitch_clr = 0;
        db_en = 1;
        ticks(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
